// File: rtl/res_checker_if.sv
// Handshake and status bundle between a result producer and the res_checker block.
interface res_checker_if;
  logic       start;
  logic       abort;
  logic [7:0] res;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_idx;
  logic [5:0] count;

  modport master (
    output start, abort, res, res_valid,
    input  res_ready, busy, done, pass, err_idx, count
  );

  modport slave (
    input  start, abort, res, res_valid,
    output res_ready, busy, done, pass, err_idx, count
  );
endinterface

// File: rtl/res_checker.sv
// Compares a stream of LEN result bytes against a constant expected vector and
// reports pass/fail, the first mismatching index and the number of bytes accepted.
module res_checker #(
  parameter int                LEN      = 16,
  parameter logic [8*LEN-1:0]  EXPECTED = '0
) (
  input  logic         clk,
  input  logic         rst,
  res_checker_if.slave chk
);

  localparam int          DATA_W = 8;
  localparam logic [5:0]  LEN_C  = 6'(LEN);
  localparam logic [5:0]  LAST_C = 6'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [4:0] err_idx_q, err_idx_d;
  logic       match_q, match_d;

  logic              accept;
  logic signed [DATA_W-1:0] exp_byte;

  // Index is clamped so a stray count can never reach past the last expected byte.
  function automatic logic [DATA_W-1:0] sel_expected(input logic [5:0] idx);
    logic [4:0] sel;
    sel = (idx < LEN_C) ? idx[4:0] : LAST_C[4:0];
    return EXPECTED[DATA_W*sel +: DATA_W];
  endfunction

  assign exp_byte = sel_expected(count_q);
  assign accept   = (state_q == RUN) && chk.res_valid && !chk.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      err_idx_q <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_idx_q <= err_idx_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_idx_d = err_idx_q;
    match_d   = match_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (chk.start) begin
          state_d   = RUN;
          count_d   = '0;
          err_idx_d = '0;
          match_d   = 1'b1;
        end
      end
      RUN: begin
        if (chk.abort) begin
          state_d = IDLE;
          match_d = 1'b0;
        end else if (accept) begin
          count_d = count_q + 6'd1;
          // Only the first mismatch of a run is recorded; match_q is still set until then.
          if ((chk.res != exp_byte) && match_q) begin
            err_idx_d = count_q[4:0];
            match_d   = 1'b0;
          end
          if (count_q == LAST_C) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chk.res_ready = (state_q == RUN);
  assign chk.busy      = (state_q == RUN);
  assign chk.done      = (state_q == DONE);
  assign chk.pass      = (state_q == DONE) && match_q;
  assign chk.err_idx   = err_idx_q;
  assign chk.count     = count_q;

endmodule

// File: tb/tb_res_checker.sv
// Directed bench for res_checker with LEN=4 and expected bytes 11,22,33,44.
module tb_res_checker;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  res_checker_if bus ();

  res_checker #(
    .LEN      (4),
    .EXPECTED (32'h44332211)
  ) dut (
    .clk (clk),
    .rst (rst),
    .chk (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic bsy, input logic dn,
                         input logic ps, input logic [4:0] ei, input logic [5:0] cnt);
    chk({tag, ".res_ready"}, 32'(bus.res_ready), 32'(rdy));
    chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
    chk({tag, ".done"},      32'(bus.done),      32'(dn));
    chk({tag, ".pass"},      32'(bus.pass),      32'(ps));
    chk({tag, ".err_idx"},   32'(bus.err_idx),   32'(ei));
    chk({tag, ".count"},     32'(bus.count),     32'(cnt));
  endtask

  task automatic send(input logic [7:0] b);
    bus.res       = b;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.res       = 8'h00;
    bus.res_valid = 1'b0;

    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 5'd0, 6'd0);
    rst = 1'b0;
    tick();
    chk_all("idle_after_reset", 0, 0, 0, 0, 5'd0, 6'd0);

    // Pass case, valid held high across all four bytes
    do_start();
    chk_all("pass_start", 1, 1, 0, 0, 5'd0, 6'd0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk_all("pass_3bytes", 1, 1, 0, 0, 5'd0, 6'd3);
    send(8'h44);
    chk_all("pass_done", 0, 0, 1, 1, 5'd0, 6'd4);

    // Abort and valid ignored while DONE
    bus.abort     = 1'b1;
    bus.res_valid = 1'b1;
    bus.res       = 8'h55;
    tick();
    bus.abort     = 1'b0;
    bus.res_valid = 1'b0;
    chk_all("done_ignores_abort", 0, 0, 1, 1, 5'd0, 6'd4);

    // Restart from DONE, then mismatches at index 1 and 3
    do_start();
    chk_all("restart", 1, 1, 0, 0, 5'd0, 6'd0);
    send(8'h11);
    send(8'h2A);
    chk_all("mis_first", 1, 1, 0, 0, 5'd1, 6'd2);
    send(8'h33);
    send(8'hFF);
    chk_all("mis_done", 0, 0, 1, 0, 5'd1, 6'd4);

    // Valid gaps of two cycles; start held high mid-run must be ignored
    do_start();
    send(8'h11);
    tick();
    chk("gap1a.count", 32'(bus.count), 32'd1);
    tick();
    chk("gap1b.count", 32'(bus.count), 32'd1);
    bus.start = 1'b1;
    send(8'h22);
    bus.start = 1'b0;
    chk("start_in_run.count", 32'(bus.count), 32'd2);
    tick();
    tick();
    chk("gap2.count", 32'(bus.count), 32'd2);
    send(8'h33);
    tick();
    tick();
    chk_all("gap3", 1, 1, 0, 0, 5'd0, 6'd3);
    send(8'h44);
    chk_all("gap_done", 0, 0, 1, 1, 5'd0, 6'd4);

    // Abort after two bytes with 0x33 on the bus
    do_start();
    send(8'h11);
    send(8'h22);
    bus.res       = 8'h33;
    bus.res_valid = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.res_valid = 1'b0;
    chk_all("abort", 0, 0, 0, 0, 5'd0, 6'd2);
    tick();
    chk_all("abort_idle_hold", 0, 0, 0, 0, 5'd0, 6'd2);
    do_start();
    chk_all("after_abort_start", 1, 1, 0, 0, 5'd0, 6'd0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk_all("after_abort_done", 0, 0, 1, 1, 5'd0, 6'd4);

    // Asynchronous reset pulsed between edges mid-run
    do_start();
    send(8'h11);
    send(8'h99);
    chk_all("pre_rst", 1, 1, 0, 0, 5'd1, 6'd2);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 5'd0, 6'd0);
    rst = 1'b0;
    bus.res       = 8'h33;
    bus.res_valid = 1'b1;
    tick();
    tick();
    bus.res_valid = 1'b0;
    chk_all("post_rst_idle", 0, 0, 0, 0, 5'd0, 6'd0);
    do_start();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk_all("post_rst_run", 0, 0, 1, 1, 5'd0, 6'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/res_checker.md
RES_CHECKER -- requirements
Module: res_checker

Interface
REQ-001 Parameter LEN, default 16, SHALL set the number of result bytes checked per run; legal range 1..32.
REQ-002 Parameter EXPECTED, default 0, width 8*LEN, SHALL hold the expected bytes; byte i = EXPECTED[8*i+7:8*i].
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  SHALL request a new check run.
REQ-006 abort  input  1  SHALL cancel a run in progress.
REQ-007 res  input  8  SHALL carry the result byte produced by the upstream transform chain.
REQ-008 res_valid  input  1  SHALL qualify res.
REQ-009 res_ready  output  1  SHALL indicate the checker accepts a byte this cycle.
REQ-010 busy  output  1  SHALL be high while in RUN.
REQ-011 done  output  1  SHALL be high while in DONE.
REQ-012 pass  output  1  SHALL be high in DONE only if all LEN bytes matched.
REQ-013 err_idx  output  5  SHALL hold the index of the first mismatching byte.
REQ-014 count  output  6  SHALL hold the number of bytes accepted in the current or last run.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 A byte SHALL be accepted only on a cycle where res_valid and res_ready are both high.
REQ-017 res_ready SHALL be combinationally high exactly when state is RUN; it SHALL not depend on res_valid.
REQ-018 IDLE with start=1 SHALL go to RUN next cycle, clearing count to 0, err_idx to 0 and the internal match flag to 1.
REQ-019 In RUN, each accepted byte SHALL be compared with expected byte [count], and count SHALL increment by 1.
REQ-020 On the first mismatch of a run, err_idx SHALL capture count's pre-increment value and the match flag SHALL clear; later mismatches SHALL not change err_idx.
REQ-021 Acceptance of byte LEN-1 SHALL move the FSM to DONE on the same edge, with count = LEN.
REQ-022 In RUN, cycles with res_valid=0 SHALL hold all state.
REQ-023 start SHALL be ignored in RUN.
REQ-024 abort=1 in RUN SHALL go to IDLE next cycle, discard any byte offered that cycle, hold count and err_idx, and clear the match flag.
REQ-025 abort SHALL be ignored in IDLE and DONE.
REQ-026 pass SHALL equal the match flag while in DONE, and SHALL be 0 in IDLE and RUN.
REQ-027 DONE with start=1 SHALL restart exactly as REQ-018; done and pass SHALL fall in the same cycle that busy rises.
REQ-028 With LEN=1, a single accepted byte SHALL complete the run.
REQ-029 Expected-byte selection SHALL never index beyond LEN-1.

Reset
REQ-030 rst=1 SHALL immediately force state to IDLE and set res_ready, busy, done, pass, err_idx and count to 0, independent of clk.
REQ-031 Reset asserted mid-RUN SHALL discard the run; after release, the block SHALL need a fresh start.
REQ-032 After rst deasserts, the first state change SHALL occur on the next rising clk edge.

Verification (LEN=4, EXPECTED=32'h44332211, so byte0=0x11)
REQ-033 Pass case: start, then bytes 11,22,33,44 with res_valid held high -> done=1, pass=1, count=4, err_idx=0, with done rising on the edge that accepts 0x44.
REQ-034 Single and multiple mismatch: bytes 11,2A,33,FF -> done=1, pass=0, err_idx=1, count=4.
REQ-035 Valid gaps: bytes 11,22,33,44 with res_valid low two cycles between each -> same result as REQ-033, and count holds during the gaps.
REQ-036 Abort: abort asserted after 2 bytes while res_valid=1 with 0x33 offered -> IDLE next cycle, count=2, pass=0, 0x33 not counted; a subsequent start and full sequence -> pass=1.
REQ-037 Async reset: rst pulsed between clock edges mid-run -> all outputs 0 before the next edge; res_ready stays 0 until a new start.
REQ-038 Restart: start asserted in DONE -> busy=1, done=0, pass=0, count=0 on the next edge, and a second full run completes correctly.
